// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction-cache (client 0) and data-cache (client 1)
// traffic onto one in-order memory port. Grant and response routing are purely
// combinational; a small ID FIFO remembers which client issued each
// outstanding read so that every response is steered back to its issuer.
//
// Build option: define MEM_ARB_FIXED_PRIORITY_EN to make client 1 win every
// conflict (the round-robin pointer is then removed). Default is round-robin.
module mem_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_c0_mem_ready,
  input  logic [31:0] i_c0_mem_addr,
  input  logic        i_c0_mem_ren,
  input  logic        i_c0_mem_wen,
  input  logic [31:0] i_c0_mem_wdata,
  output logic [31:0] o_c0_mem_rdata,
  output logic        o_c0_mem_valid,
  output logic        o_c1_mem_ready,
  input  logic [31:0] i_c1_mem_addr,
  input  logic        i_c1_mem_ren,
  input  logic        i_c1_mem_wen,
  input  logic [31:0] i_c1_mem_wdata,
  output logic [31:0] o_c1_mem_rdata,
  output logic        o_c1_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          c0_req;
  logic          c1_req;
  logic          c0_rd;
  logic          c1_rd;
  logic          accept_ok;
  logic          pref_c1;
  logic          c0_acc;
  logic          c1_acc;
  logic          push;
  logic          pop;
  logic          head_id;
  logic [CW-1:0] count;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          id_mem [DEPTH];
  logic          err_q;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // A client asserting both strobes is treated as a write; its read is masked.
  assign c0_req = i_c0_mem_ren | i_c0_mem_wen;
  assign c1_req = i_c1_mem_ren | i_c1_mem_wen;
  assign c0_rd  = i_c0_mem_ren & ~i_c0_mem_wen;
  assign c1_rd  = i_c1_mem_ren & ~i_c1_mem_wen;

  // No bypass when full: a same-cycle pop does not free a slot for a push.
  assign accept_ok = i_mem_ready & (count < CW'(DEPTH)) & ~i_rst;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign pref_c1 = 1'b1;
`else
  logic last;

  assign pref_c1 = ~last;

  // Remember the most recently granted client; reset favours client 0 first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last <= 1'b1;
    end else if (c0_acc | c1_acc) begin
      last <= c1_acc;
    end
  end
`endif

  // pref_c1 only matters on a conflict; an idle client still sees ready when
  // it would win, so a cache that issues only on ready is never starved.
  assign o_c0_mem_ready = accept_ok & (~c1_req | ~pref_c1);
  assign o_c1_mem_ready = accept_ok & (~c0_req | pref_c1);
  assign c0_acc = c0_req & o_c0_mem_ready;
  assign c1_acc = c1_req & o_c1_mem_ready;

  assign o_mem_ren   = (c0_acc & c0_rd) | (c1_acc & c1_rd);
  assign o_mem_wen   = (c0_acc & i_c0_mem_wen) | (c1_acc & i_c1_mem_wen);
  assign o_mem_addr  = c1_acc ? i_c1_mem_addr  : i_c0_mem_addr;
  assign o_mem_wdata = c1_acc ? i_c1_mem_wdata : i_c0_mem_wdata;

  // Only reads are tracked; the pushed ID is simply "client 1 was granted".
  assign push    = o_mem_ren;
  assign pop     = i_mem_valid & (count != '0) & ~i_rst;
  assign head_id = id_mem[rptr];

  assign o_c0_mem_valid = pop & ~head_id;
  assign o_c1_mem_valid = pop & head_id;
  assign o_c0_mem_rdata = i_mem_rdata;
  assign o_c1_mem_rdata = i_mem_rdata;
  assign o_err          = err_q;

  // ID FIFO occupancy and pointers; reset drops every outstanding ID.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push & ~pop) begin
        count <= count + CW'(1);
      end else if (pop & ~push) begin
        count <= count - CW'(1);
      end
    end
  end

  // ID storage; contents are meaningless outside the count window, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) id_mem[wptr] <= c1_acc;
  end

  // Sticky error: a response arrived while nothing was outstanding.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (i_mem_valid & (count == '0)) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY 4 / INTERVAL 2 memory model (with
// a manual override for stall and spurious-response cases) and two client
// request queues, all driven from one process on the falling edge.
module tb_mem_arbiter;

  localparam int LAT      = 4;
  localparam int INTERVAL = 2;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c0_ready, c1_ready;
  logic [31:0] c0_addr = '0, c1_addr = '0;
  logic        c0_ren = 1'b0, c0_wen = 1'b0, c1_ren = 1'b0, c1_wen = 1'b0;
  logic [31:0] c0_wdata = '0, c1_wdata = '0;
  logic [31:0] c0_rdata, c1_rdata;
  logic        c0_valid, c1_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic        err;

  logic        man = 1'b0;
  logic        man_ready = 1'b0;
  logic        man_valid = 1'b0;
  logic [31:0] man_rdata = '0;

  op_t         q0[$];
  op_t         q1[$];
  resp_t       pend[$];
  resp_t       r_tmp;
  logic [31:0] got0[$];
  logic [31:0] got1[$];
  logic [31:0] rd_addr[$];
  logic [31:0] mem_arr [0:4095];
  int          n_rd = 0;
  int          n_wr = 0;
  int          cyc = 0;
  int          busy_until = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_ord [4];
  logic [31:0] exp_first;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(4)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_c0_mem_ready (c0_ready),
    .i_c0_mem_addr  (c0_addr),
    .i_c0_mem_ren   (c0_ren),
    .i_c0_mem_wen   (c0_wen),
    .i_c0_mem_wdata (c0_wdata),
    .o_c0_mem_rdata (c0_rdata),
    .o_c0_mem_valid (c0_valid),
    .o_c1_mem_ready (c1_ready),
    .i_c1_mem_addr  (c1_addr),
    .i_c1_mem_ren   (c1_ren),
    .i_c1_mem_wen   (c1_wen),
    .i_c1_mem_wdata (c1_wdata),
    .o_c1_mem_rdata (c1_rdata),
    .o_c1_mem_valid (c1_valid),
    .i_mem_ready    (mem_ready),
    .o_mem_addr     (mem_addr),
    .o_mem_ren      (mem_ren),
    .o_mem_wen      (mem_wen),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata),
    .i_mem_valid    (mem_valid),
    .o_err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic push_op(input bit cid, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    op_t op;
    op.wr = wr;
    op.addr = addr;
    op.wdata = wdata;
    if (cid) q1.push_back(op);
    else q0.push_back(op);
  endtask

  task automatic clear_logs();
    got0.delete();
    got1.delete();
    rd_addr.delete();
    n_rd = 0;
    n_wr = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int  n;
    logic idle;
    n = 0;
    idle = (q0.size() == 0) && (q1.size() == 0) && (pend.size() == 0);
    while (!idle && n < max_cyc) begin
      @(negedge clk);
      n++;
      idle = (q0.size() == 0) && (q1.size() == 0) && (pend.size() == 0);
    end
    chk(tag, 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Memory model, client drivers and response monitor.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend.delete();
        busy_until = 0;
      end
      if (man) begin
        mem_ready = man_ready;
        mem_valid = man_valid;
        mem_rdata = man_rdata;
      end else begin
        mem_ready = (cyc >= busy_until);
        mem_valid = 1'b0;
        mem_rdata = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          mem_valid = 1'b1;
          mem_rdata = pend[0].data;
          void'(pend.pop_front());
        end
      end
      if (q0.size() > 0) begin
        c0_ren = ~q0[0].wr; c0_wen = q0[0].wr; c0_addr = q0[0].addr; c0_wdata = q0[0].wdata;
      end else begin
        c0_ren = 1'b0; c0_wen = 1'b0; c0_addr = '0; c0_wdata = '0;
      end
      if (q1.size() > 0) begin
        c1_ren = ~q1[0].wr; c1_wen = q1[0].wr; c1_addr = q1[0].addr; c1_wdata = q1[0].wdata;
      end else begin
        c1_ren = 1'b0; c1_wen = 1'b0; c1_addr = '0; c1_wdata = '0;
      end
      #3;
      if (mem_ren) begin
        n_rd++;
        rd_addr.push_back(mem_addr);
        if (!man) begin
          r_tmp.due = cyc + LAT;
          r_tmp.data = mem_arr[mem_addr[11:0]];
          pend.push_back(r_tmp);
        end
      end
      if (mem_wen) begin
        n_wr++;
        mem_arr[mem_addr[11:0]] = mem_wdata;
      end
      if (mem_ren || mem_wen) busy_until = cyc + 1 + INTERVAL;
      if (q0.size() > 0 && c0_ready) void'(q0.pop_front());
      if (q1.size() > 0 && c1_ready) void'(q1.pop_front());
      if (c0_valid) got0.push_back(c0_rdata);
      if (c1_valid) got1.push_back(c1_rdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'hA000_0000 | 32'(i);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp_ord[0] = 32'h200; exp_ord[1] = 32'h204; exp_ord[2] = 32'h100; exp_ord[3] = 32'h104;
    exp_first = 32'hDEAD_BEEF;
`else
    exp_ord[0] = 32'h100; exp_ord[1] = 32'h200; exp_ord[2] = 32'h104; exp_ord[3] = 32'h204;
    exp_first = 32'hA000_0040;
`endif

    // Reset state: memory is ready, yet nothing may be granted.
    repeat (3) @(negedge clk);
    #4;
    chk("rst_c0_ready", 32'(c0_ready), 32'd0);
    chk("rst_c1_ready", 32'(c1_ready), 32'd0);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(u_dut.count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Line fill from client 1.
    clear_logs();
    for (int i = 0; i < 4; i++) push_op(1'b1, 1'b0, 32'h10 + 32'(4 * i), '0);
    wait_idle("fill_idle", 200);
    chk("fill_n_rd", 32'(n_rd), 32'd4);
    chk("fill_n_c1", 32'(got1.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("fill_data", (got1.size() > i) ? got1[i] : 32'h0, 32'hA000_0010 + 32'(4 * i));
    chk("fill_n_c0", 32'(got0.size()), 32'd0);
    chk("fill_count", 32'(u_dut.count), 32'd0);

    // Simultaneous read strobes right after reset.
    do_reset(2);
    clear_logs();
    push_op(1'b0, 1'b0, 32'h100, '0);
    push_op(1'b0, 1'b0, 32'h104, '0);
    push_op(1'b1, 1'b0, 32'h200, '0);
    push_op(1'b1, 1'b0, 32'h204, '0);
    wait_idle("rr_idle", 200);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (rd_addr.size() > i) ? rd_addr[i] : 32'h0, exp_ord[i]);
    chk("rr_c0_d0", (got0.size() > 0) ? got0[0] : 32'h0, 32'hA000_0100);
    chk("rr_c0_d1", (got0.size() > 1) ? got0[1] : 32'h0, 32'hA000_0104);
    chk("rr_c1_d0", (got1.size() > 0) ? got1[0] : 32'h0, 32'hA000_0200);
    chk("rr_c1_d1", (got1.size() > 1) ? got1[1] : 32'h0, 32'hA000_0204);

    // Write/read interleave on the same word.
    clear_logs();
    push_op(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    push_op(1'b0, 1'b0, 32'h40, '0);
    wait_idle("wr_idle0", 200);
    push_op(1'b0, 1'b0, 32'h40, '0);
    wait_idle("wr_idle1", 200);
    push_op(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D);
    push_op(1'b0, 1'b0, 32'h44, '0);
    wait_idle("wr_idle2", 200);
    chk("wr_n_wr", 32'(n_wr), 32'd2);
    chk("wr_n_c1", 32'(got1.size()), 32'd0);
    chk("wr_n_c0", 32'(got0.size()), 32'd3);
    chk("wr_first", (got0.size() > 0) ? got0[0] : 32'h0, exp_first);
    chk("wr_after", (got0.size() > 1) ? got0[1] : 32'h0, 32'hDEAD_BEEF);
    chk("wr_first_wins", (got0.size() > 2) ? got0[2] : 32'h0, 32'hCAFE_F00D);

    // FIFO full: memory always ready, no responses.
    man = 1'b1; man_ready = 1'b1; man_valid = 1'b0; man_rdata = '0;
    clear_logs();
    for (int i = 0; i < 5; i++) push_op(1'b0, 1'b0, 32'h300 + 32'(i), '0);
    repeat (6) @(negedge clk);
    #4;
    chk("full_count", 32'(u_dut.count), 32'd4);
    chk("full_c0_ready", 32'(c0_ready), 32'd0);
    chk("full_c1_ready", 32'(c1_ready), 32'd0);
    chk("full_n_rd", 32'(n_rd), 32'd4);
    @(negedge clk);
    man_valid = 1'b1; man_rdata = 32'h55;
    #4;
    chk("full_pop_ready", 32'(c0_ready), 32'd0);
    chk("full_pop_c0v", 32'(c0_valid), 32'd1);
    chk("full_pop_c1v", 32'(c1_valid), 32'd0);
    chk("full_pop_data", c0_rdata, 32'h55);
    @(negedge clk);
    man_valid = 1'b0;
    #4;
    chk("full_next_ready", 32'(c0_ready), 32'd1);
    chk("full_next_ren", 32'(mem_ren), 32'd1);
    chk("full_next_addr", mem_addr, 32'h304);
    @(negedge clk);
    #4;
    chk("full_refill", 32'(u_dut.count), 32'd4);

    // Spurious response with nothing outstanding.
    do_reset(2);
    #4;
    chk("sp_count", 32'(u_dut.count), 32'd0);
    @(negedge clk);
    man_valid = 1'b1; man_rdata = 32'h77;
    #4;
    chk("sp_c0v", 32'(c0_valid), 32'd0);
    chk("sp_c1v", 32'(c1_valid), 32'd0);
    chk("sp_err_pre", 32'(err), 32'd0);
    @(negedge clk);
    man_valid = 1'b0;
    #4;
    chk("sp_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    #4;
    chk("sp_err_sticky", 32'(err), 32'd1);

    // Reset with three reads outstanding, then a clean round trip.
    @(negedge clk);
    clear_logs();
    for (int i = 0; i < 3; i++) push_op(1'b0, 1'b0, 32'h500 + 32'(i), '0);
    repeat (4) @(negedge clk);
    #4;
    chk("mr_count3", 32'(u_dut.count), 32'd3);
    @(negedge clk);
    rst = 1'b1; man_valid = 1'b1; man_rdata = 32'h99;
    push_op(1'b1, 1'b0, 32'h600, '0);
    #4;
    chk("mr_c0_ready", 32'(c0_ready), 32'd0);
    chk("mr_c1_ready", 32'(c1_ready), 32'd0);
    chk("mr_ren", 32'(mem_ren), 32'd0);
    chk("mr_c0v", 32'(c0_valid), 32'd0);
    chk("mr_c1v", 32'(c1_valid), 32'd0);
    @(negedge clk);
    man_valid = 1'b0;
    #4;
    chk("mr_count0", 32'(u_dut.count), 32'd0);
    chk("mr_err_clr", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0; man = 1'b0;
    wait_idle("mr_idle", 200);
    chk("mr_n_c1", 32'(got1.size()), 32'd1);
    chk("mr_data", (got1.size() > 0) ? got1[0] : 32'h0, 32'hA000_0600);
    chk("mr_n_c0", 32'(got0.size()), 32'd0);
    chk("mr_count_end", 32'(u_dut.count), 32'd0);
    chk("mr_err_end", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
